jt10_adpcm_interp: RTL and testbench
====================================

JT10_ADPCM_INTERP -- requirements
Module: jt10_adpcm_interp

Interface
REQ-001 SHALL have parameter CHANNELS, default 6, number of time-multiplexed channels summed per frame (2..16).
REQ-002 SHALL have parameter STEPS, default 3, interpolated output points per frame; must divide CHANNELS.
REQ-003 SHALL have parameter IW, default 16, signed input sample width.
REQ-004 SHALL have parameter OW, default 16, signed output width, OW <= IW + clog2(CHANNELS).
REQ-005 SHALL have parameter FRAC, default 10, fractional bits of the reciprocal RECIP = round(2^FRAC / STEPS), which is 341 at the defaults.
REQ-006 clk  in  1  system clock; single clock domain.
REQ-007 rst  in  1  synchronous, active-high reset.
REQ-008 cen  in  1  channel-slot enable, one channel per cen.
REQ-009 cur_ch  in  clog2(CHANNELS)  channel index of pcm_in.
REQ-010 ch_mute  in  CHANNELS  per-channel mute mask; a set bit means the channel contributes 0.
REQ-011 pcm_in  in  IW signed  channel sample.
REQ-012 pcm_out  out  OW signed  registered, saturated, interpolated mix.
REQ-013 pcm_valid  out  1  one-clk pulse when pcm_out takes a new interpolation point.
REQ-014 sat  out  1  one-clk pulse coincident with pcm_valid when that point was clipped.

Function
REQ-015 Accumulator width AW = IW + clog2(CHANNELS) + 1; all internal sums SHALL be AW-bit signed, sign-extended, and never wrap.
REQ-016 On cen with cur_ch==0: acc <= masked pcm_in; last <= acc; base <= last; step <= ((acc - last) * RECIP) >>> FRAC, arithmetic shift, floor.
REQ-017 On cen with 0 < cur_ch < CHANNELS: acc <= acc + masked pcm_in.
REQ-018 A cen with cur_ch >= CHANNELS SHALL be ignored completely: no state change and no pcm_valid.
REQ-019 Interp register SHALL load last (pre-update) at cur_ch==0, and SHALL add step at cur_ch == k*CHANNELS/STEPS for k = 1..STEPS-1.
REQ-020 Latency: every load or step event SHALL update pcm_out and pulse pcm_valid exactly one clk after the cen that caused it; one frame gives STEPS pulses.
REQ-021 Saturation: when the interp value exceeds the OW signed range, pcm_out SHALL be 2^(OW-1)-1 or -2^(OW-1) and sat SHALL pulse.
REQ-022 ch_mute SHALL be sampled on the same cen as its channel; changing it mid-frame affects only slots not yet accumulated.
REQ-023 Output is one frame behind the input: the frame summed in frame n is reached by interpolation at the end of frame n+1.

Reset
REQ-024 rst SHALL have priority over cen.
REQ-025 rst SHALL clear acc, last, base, step, the interp register, pcm_out, pcm_valid and sat to 0.
REQ-026 rst asserted mid-frame SHALL discard the partial frame; the first frame after reset starts at the next cur_ch==0.

Configuration
REQ-027 Macro JT10_ADPCM_INTERP_EN: when defined, behaviour SHALL be as REQ-016..REQ-020.
REQ-028 When JT10_ADPCM_INTERP_EN is undefined, step logic SHALL be removed and behaviour becomes sample-and-hold: only the cur_ch==0 load occurs, giving one pcm_valid per frame, and pcm_out holds between loads.

Verification (CHANNELS=6, STEPS=3, IW=OW=16, macro defined unless noted)
REQ-029 Reset: rst high for 2 clk with cen toggling -> pcm_out=0, pcm_valid=0, sat=0 throughout.
REQ-030 Ramp: frames sum to 0, then 3072, then 3072 -> pcm_valid values 0, 1023, 2046, then 3072, 3072, 3072.
REQ-031 Saturation: all channels 0x7FFF for 3 frames -> pcm_out 0x7FFF with sat pulses; then all 0x8000 -> pcm_out 0x8000 with sat pulses.
REQ-032 Mute: ch0=5000, others=100, ch_mute=6'b000001 -> steady pcm_out 500; clear the mask -> steady 5500.
REQ-033 Out-of-range slot: extra cen with cur_ch=7, pcm_in=9999 mid-frame -> output sequence identical to the same run without that slot.
REQ-034 Macro undefined, ramp stimulus of REQ-030 -> one pcm_valid per frame, values 0, 3072, 3072.

Source files
------------

// File: rtl/jt10_adpcm_interp.sv
// Time-multiplexed ADPCM channel mixer with linear interpolation between frame sums.
// Define JT10_ADPCM_INTERP_EN for interpolation; otherwise the output is sample-and-hold per frame.
module jt10_adpcm_interp #(
    parameter  int CHANNELS = 6,
    parameter  int STEPS    = 3,
    parameter  int IW       = 16,
    parameter  int OW       = 16,
    parameter  int FRAC     = 10,
    localparam int CW       = $clog2(CHANNELS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cen,
    input  logic [CW-1:0]        cur_ch,
    input  logic [CHANNELS-1:0]  ch_mute,
    input  logic signed [IW-1:0] pcm_in,
    output logic signed [OW-1:0] pcm_out,
    output logic                 pcm_valid,
    output logic                 sat
);
    localparam int AW = IW + CW + 1;
    localparam logic signed [AW-1:0] OMAX = {{(AW-OW+1){1'b0}}, {(OW-1){1'b1}}};
    localparam logic signed [AW-1:0] OMIN = ~OMAX;

    logic signed [AW-1:0] acc, last, interp, interp_nxt, masked;
    logic signed [OW-1:0] out_nxt;
    logic                 synced, in_range, load, clip;

    assign in_range = int'(cur_ch) < CHANNELS;
    assign masked   = ch_mute[cur_ch] ? '0 : AW'(pcm_in);

`ifdef JT10_ADPCM_INTERP_EN
    localparam int SPAN  = CHANNELS / STEPS;
    localparam int RECIP = ((1 << FRAC) + STEPS / 2) / STEPS;
    localparam int PW    = AW + FRAC + 2;

    logic signed [AW-1:0] base, step, step_nxt;
    logic signed [PW-1:0] prod;
    logic                 is_step, first_step;

    always_comb begin
        is_step = 1'b0;
        for (int unsigned k = 1; k < STEPS; k++)
            if (int'(cur_ch) == int'(k) * SPAN) is_step = 1'b1;
    end

    assign first_step = int'(cur_ch) == SPAN;
    assign prod       = (PW'(acc) - PW'(last)) * PW'(RECIP);
    assign step_nxt   = AW'(prod >>> FRAC);
`endif

    always_comb begin
        interp_nxt = interp;
        load       = 1'b0;
        if (cen && in_range) begin
            if (cur_ch == '0) begin
                interp_nxt = last;
                load       = 1'b1;
            end
`ifdef JT10_ADPCM_INTERP_EN
            // interp equals base at the first step point, so base + step is the same sum
            else if (synced && is_step) begin
                interp_nxt = (first_step ? base : interp) + step;
                load       = 1'b1;
            end
`endif
        end
    end

    always_comb begin
        clip = 1'b1;
        if (interp_nxt > OMAX)
            out_nxt = OMAX[OW-1:0];
        else if (interp_nxt < OMIN)
            out_nxt = OMIN[OW-1:0];
        else begin
            clip    = 1'b0;
            out_nxt = interp_nxt[OW-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc       <= '0;
            last      <= '0;
            interp    <= '0;
            pcm_out   <= '0;
            pcm_valid <= 1'b0;
            sat       <= 1'b0;
            synced    <= 1'b0;
`ifdef JT10_ADPCM_INTERP_EN
            base      <= '0;
            step      <= '0;
`endif
        end else begin
            pcm_valid <= load;
            sat       <= load & clip;
            interp    <= interp_nxt;
            if (load) pcm_out <= out_nxt;
            if (cen && in_range) begin
                if (cur_ch == '0) begin
                    synced <= 1'b1;
                    acc    <= masked;
                    last   <= acc;
`ifdef JT10_ADPCM_INTERP_EN
                    base   <= last;
                    step   <= step_nxt;
`endif
                end else if (synced) begin
                    // slots before the first channel-0 after reset belong to a discarded frame
                    acc <= acc + masked;
                end
            end
        end
    end
endmodule

// File: tb/tb_jt10_adpcm_interp.sv
// Self-checking bench for jt10_adpcm_interp; models frames as a list of sums and derives
// the expected output points from the frame history.
module tb_jt10_adpcm_interp;
    localparam int CH    = 6;
    localparam int STP   = 3;
    localparam int SPAN  = CH / STP;
    localparam int RECIP = 341;

    typedef struct packed {
        int   tag;
        int   val;
        logic sat;
    } pulse_t;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               cen = 1'b0;
    logic [2:0]         cur_ch = '0;
    logic [CH-1:0]      ch_mute = '0;
    logic signed [15:0] pcm_in = '0;
    logic signed [15:0] pcm_out;
    logic               pcm_valid, sat;

    int total = 0;
    int bad   = 0;
    int fr    = 0;
    int tag   = -1;
    int     hist[$];
    pulse_t exp_q[$];
    pulse_t obs_q[$];

    jt10_adpcm_interp #(.CHANNELS(6), .STEPS(3), .IW(16), .OW(16), .FRAC(10)) dut (
        .clk(clk), .rst(rst), .cen(cen), .cur_ch(cur_ch), .ch_mute(ch_mute),
        .pcm_in(pcm_in), .pcm_out(pcm_out), .pcm_valid(pcm_valid), .sat(sat)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (pcm_valid) obs_q.push_back(pulse_t'{tag, int'(pcm_out), sat});
        else if (sat) obs_q.push_back(pulse_t'{-2, int'(pcm_out), sat});
    end

    function automatic longint floor_div(input longint p, input longint d);
        return (p >= 0) ? p / d : -((-p + d - 1) / d);
    endfunction

    function automatic void exp_push(input int tg, input longint v);
        pulse_t p;
        p.tag = tg;
        if (v > 32767) begin p.val = 32767; p.sat = 1'b1; end
        else if (v < -32768) begin p.val = -32768; p.sat = 1'b1; end
        else begin p.val = int'(v); p.sat = 1'b0; end
        exp_q.push_back(p);
    endfunction

    // Frame f starts at the sum of frame f-2 and moves toward the sum of frame f-1.
    function automatic void model_frame(input int sum, input int frame);
        int     f = hist.size();
        longint l = (f >= 2) ? hist[f-2] : 0;
        longint p = (f >= 1) ? hist[f-1] : 0;
        exp_push(frame * 16, l);
`ifdef JT10_ADPCM_INTERP_EN
        begin
            longint st = floor_div((p - l) * RECIP, 1024);
            for (int k = 1; k < STP; k++) exp_push(frame * 16 + k * SPAN, l + k * st);
        end
`else
        if (p != p) exp_push(-9, 0);
`endif
        hist.push_back(sum);
    endfunction

    task automatic drive_slot(input int ch, input int val, input logic [CH-1:0] mute, input int tg);
        cur_ch = 3'(ch); pcm_in = 16'(val); ch_mute = mute; cen = 1'b1;
        @(posedge clk); #1;
        tag = tg; cen = 1'b0;
        @(posedge clk); #1;
        tag = -1;
    endtask

    task automatic drive_frame(input int v[CH], input logic [CH-1:0] mute, input int oor_after);
        int sum = 0;
        for (int i = 0; i < CH; i++) if (!mute[i]) sum += v[i];
        model_frame(sum, fr);
        for (int c = 0; c < CH; c++) begin
            drive_slot(c, v[c], mute, fr * 16 + c);
            if (c == oor_after) begin
                drive_slot(7, 9999, mute, -3);
                drive_slot(6, -1234, mute, -3);
            end
        end
        fr++;
    endtask

    task automatic do_reset();
        rst = 1'b1; cen = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        tag = -1;
        hist.delete(); exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_reset();
        for (int i = 0; i < 4; i++) begin
            rst = 1'b1; cen = 1'(i % 2); cur_ch = '0; pcm_in = 16'($urandom);
            @(posedge clk); #1;
            total++; if (pcm_out !== 16'sd0) begin bad++; $display("FAIL reset_out: got %0d need 0", pcm_out); end
            total++; if (pcm_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b need 0", pcm_valid); end
            total++; if (sat !== 1'b0) begin bad++; $display("FAIL reset_sat: got %b need 0", sat); end
        end
        do_reset();
    endtask

    task automatic test_ramp();
`ifdef JT10_ADPCM_INTERP_EN
        int hard[15] = '{0, 0, 0, 0, 0, 0, 0, 1023, 2046, 3072, 3072, 3072, 3072, 3072, 3072};
`else
        int hard[5] = '{0, 0, 0, 3072, 3072};
`endif
        int z[CH] = '{0, 0, 0, 0, 0, 0};
        int r[CH] = '{512, 512, 512, 512, 512, 512};
        do_reset();
        drive_frame(z, '0, -1);
        repeat (4) drive_frame(r, '0, -1);
        total++;
        if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL ramp_count: got %0d need %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            total++;
            if (obs_q[i] !== exp_q[i]) begin bad++;
                $display("FAIL ramp[%0d]: got tag=%0d out=%0d sat=%0d need tag=%0d out=%0d sat=%0d", i,
                         obs_q[i].tag, obs_q[i].val, obs_q[i].sat, exp_q[i].tag, exp_q[i].val, exp_q[i].sat); end
        end
        for (int i = 0; i < $size(hard); i++) begin
            total++;
            if (i >= obs_q.size()) begin bad++; $display("FAIL ramp_value[%0d]: got none need %0d", i, hard[i]); end
            else if (obs_q[i].val !== hard[i]) begin bad++; $display("FAIL ramp_value[%0d]: got %0d need %0d", i, obs_q[i].val, hard[i]); end
        end
    endtask

    task automatic test_saturation();
        int hi[CH] = '{32767, 32767, 32767, 32767, 32767, 32767};
        int lo[CH] = '{-32768, -32768, -32768, -32768, -32768, -32768};
        do_reset();
        repeat (4) drive_frame(hi, '0, -1);
        repeat (4) drive_frame(lo, '0, -1);
        total++;
        if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL sat_count: got %0d need %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            total++;
            if (obs_q[i] !== exp_q[i]) begin bad++;
                $display("FAIL sat[%0d]: got tag=%0d out=%0d sat=%0d need tag=%0d out=%0d sat=%0d", i,
                         obs_q[i].tag, obs_q[i].val, obs_q[i].sat, exp_q[i].tag, exp_q[i].val, exp_q[i].sat); end
        end
        total++;
        if (obs_q.size() == 0 || obs_q[$].val !== -32768 || obs_q[$].sat !== 1'b1) begin bad++;
            $display("FAIL sat_final: got out=%0d need -32768 with sat", (obs_q.size() == 0) ? 0 : obs_q[$].val); end
    endtask

    task automatic test_mute();
        int v[CH] = '{5000, 100, 100, 100, 100, 100};
        do_reset();
        repeat (4) drive_frame(v, 6'b000001, -1);
        repeat (4) drive_frame(v, 6'b000000, -1);
        total++;
        if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL mute_count: got %0d need %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            total++;
            if (obs_q[i] !== exp_q[i]) begin bad++;
                $display("FAIL mute[%0d]: got tag=%0d out=%0d sat=%0d need tag=%0d out=%0d sat=%0d", i,
                         obs_q[i].tag, obs_q[i].val, obs_q[i].sat, exp_q[i].tag, exp_q[i].val, exp_q[i].sat); end
        end
        total++;
        if (obs_q.size() == 0 || obs_q[$].val !== 5500) begin bad++;
            $display("FAIL mute_final: got %0d need 5500", (obs_q.size() == 0) ? 0 : obs_q[$].val); end
    endtask

    task automatic test_out_of_range();
        int v[CH];
        do_reset();
        repeat (4) begin
            for (int i = 0; i < CH; i++) v[i] = int'($urandom_range(0, 8000)) - 4000;
            drive_frame(v, '0, int'($urandom_range(0, CH - 1)));
        end
        total++;
        if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL oor_count: got %0d need %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            total++;
            if (obs_q[i] !== exp_q[i]) begin bad++;
                $display("FAIL oor[%0d]: got tag=%0d out=%0d sat=%0d need tag=%0d out=%0d sat=%0d", i,
                         obs_q[i].tag, obs_q[i].val, obs_q[i].sat, exp_q[i].tag, exp_q[i].val, exp_q[i].sat); end
        end
    endtask

    task automatic test_random();
        int v[CH];
        do_reset();
        repeat (8) begin
            for (int i = 0; i < CH; i++) v[i] = int'($urandom_range(0, 65535)) - 32768;
            drive_frame(v, 6'($urandom_range(0, 63)), -1);
        end
        total++;
        if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL rand_count: got %0d need %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            total++;
            if (obs_q[i] !== exp_q[i]) begin bad++;
                $display("FAIL rand[%0d]: got tag=%0d out=%0d sat=%0d need tag=%0d out=%0d sat=%0d", i,
                         obs_q[i].tag, obs_q[i].val, obs_q[i].sat, exp_q[i].tag, exp_q[i].val, exp_q[i].sat); end
        end
    endtask

    task automatic test_midframe_reset();
        int v[CH];
        do_reset();
        for (int c = 0; c < 4; c++) drive_slot(c, 30000, '0, -4);
        do_reset();
        total++; if (pcm_out !== 16'sd0) begin bad++; $display("FAIL mid_reset_out: got %0d need 0", pcm_out); end
        total++; if (pcm_valid !== 1'b0) begin bad++; $display("FAIL mid_reset_valid: got %b need 0", pcm_valid); end
        drive_slot(4, 20000, '0, -5);
        drive_slot(5, 20000, '0, -5);
        repeat (4) begin
            for (int i = 0; i < CH; i++) v[i] = int'($urandom_range(0, 2000)) - 1000;
            drive_frame(v, '0, -1);
        end
        total++;
        if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL mid_count: got %0d need %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            total++;
            if (obs_q[i] !== exp_q[i]) begin bad++;
                $display("FAIL mid[%0d]: got tag=%0d out=%0d sat=%0d need tag=%0d out=%0d sat=%0d", i,
                         obs_q[i].tag, obs_q[i].val, obs_q[i].sat, exp_q[i].tag, exp_q[i].val, exp_q[i].sat); end
        end
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_saturation();
        test_mute();
        test_out_of_range();
        test_random();
        test_midframe_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
